// File: rtl/smalldiv_pkg.sv
// Shared helpers for the small-constant divider: the elaboration-time
// table-entry generator and the digit width helper used by the parent divider.
package smalldiv_pkg;

    // One table entry, packed as {quotient, remainder} in the low
    // (digit_width + divider_width) bits. The quotient is truncated to
    // digit_width bits, which only matters for an out-of-range remainder input.
    function automatic logic [63:0] lut_entry(
        input int index,
        input int divider_value,
        input int digit_width,
        input int divider_width
    );
        longint unsigned v;
        longint unsigned dv;
        longint unsigned q;
        longint unsigned r;
        longint unsigned q_mask;
        v      = 64'(unsigned'(index));
        dv     = 64'(unsigned'(divider_value));
        q      = v / dv;
        r      = v % dv;
        q_mask = (64'd1 << digit_width) - 64'd1;
        return ((q & q_mask) << divider_width) | r;
    endfunction

    // Digit width for a divider built from LUTs of lut_width address bits:
    // whatever is left after the remainder bits, but never narrower than the
    // remainder itself.
    function automatic int digit_width_for(
        input int lut_width,
        input int divider_width
    );
        if ((lut_width - divider_width) > divider_width) begin
            return lut_width - divider_width;
        end else begin
            return divider_width;
        end
    endfunction

endpackage : smalldiv_pkg

// File: rtl/smalldiv_digit_lut.sv
// One digit stage of a small-constant long divider. Divides
// {last_remainder, dividend_digit} by DIVIDER_VALUE using a lookup table that
// is filled at elaboration, producing a quotient digit and a new remainder.
// Outputs are optionally registered (REGISTER_OUT=1, latency 1).
module smalldiv_digit_lut
    import smalldiv_pkg::*;
#(
    parameter int DIVIDER_VALUE = 5,
    parameter int DIVIDER_WIDTH = $clog2(DIVIDER_VALUE),
    parameter int DIGIT_WIDTH   = 3,
    parameter bit REGISTER_OUT  = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DIGIT_WIDTH-1:0]   dividend_digit,
    input  logic [DIVIDER_WIDTH-1:0] last_remainder,
    output logic [DIGIT_WIDTH-1:0]   quotient,
    output logic [DIVIDER_WIDTH-1:0] remainder
);

    localparam int IDX_W     = DIGIT_WIDTH + DIVIDER_WIDTH;
    localparam int LUT_DEPTH = 1 << IDX_W;

    // Parameter sanity: reject configurations the table cannot represent.
    if (DIVIDER_VALUE < 2) begin : g_bad_divider
        $error("smalldiv_digit_lut: DIVIDER_VALUE must be >= 2");
    end
    if (DIVIDER_WIDTH < $clog2(DIVIDER_VALUE)) begin : g_bad_div_width
        $error("smalldiv_digit_lut: DIVIDER_WIDTH too narrow for DIVIDER_VALUE");
    end
    if (DIGIT_WIDTH < 1) begin : g_bad_digit_width
        $error("smalldiv_digit_lut: DIGIT_WIDTH must be >= 1");
    end

    // Constant table: every entry is an elaboration-time constant, so this
    // reduces to a ROM and no runtime divider is built.
    logic [IDX_W-1:0] w_table [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_table
        assign w_table[gi] = IDX_W'(lut_entry(gi, DIVIDER_VALUE, DIGIT_WIDTH, DIVIDER_WIDTH));
    end

    logic [IDX_W-1:0]         w_index;
    logic [IDX_W-1:0]         w_entry;
    logic [DIGIT_WIDTH-1:0]   w_quotient;
    logic [DIVIDER_WIDTH-1:0] w_remainder;

    // Pure lookup on the concatenated remainder and digit.
    assign w_index     = {last_remainder, dividend_digit};
    assign w_entry     = w_table[w_index];
    assign w_quotient  = w_entry[IDX_W-1 -: DIGIT_WIDTH];
    assign w_remainder = w_entry[DIVIDER_WIDTH-1:0];

    if (REGISTER_OUT) begin : g_registered
        logic [DIGIT_WIDTH-1:0]   r_quotient;
        logic [DIVIDER_WIDTH-1:0] r_remainder;

        // Output register: async clear, load on enable, otherwise hold.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_quotient  <= '0;
                r_remainder <= '0;
            end else if (enable) begin
                r_quotient  <= w_quotient;
                r_remainder <= w_remainder;
            end else begin
                r_quotient  <= r_quotient;
                r_remainder <= r_remainder;
            end
        end

        assign quotient  = r_quotient;
        assign remainder = r_remainder;
    end else begin : g_combinational
        // Zero-latency path; clock, reset and enable play no part here.
        assign quotient  = w_quotient;
        assign remainder = w_remainder;
    end

endmodule : smalldiv_digit_lut

// File: tb/tb_smalldiv_digit_lut.sv
// Self-checking bench for smalldiv_digit_lut: a registered D=5 stage checked
// against plain integer division, plus combinational D=3 stages (single and
// six-stage chain) checked the same way.
module tb_smalldiv_digit_lut;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] dividend_digit;
    logic [2:0] last_remainder;
    logic [2:0] quotient;
    logic [2:0] remainder;

    // Combinational single stage, D=3, 4-bit digits.
    logic [3:0] c1_digit;
    logic [1:0] c1_last;
    logic [3:0] c1_quot;
    logic [1:0] c1_rem;

    // Six-stage combinational chain on a 24-bit dividend.
    logic [23:0] ch_dividend;
    logic [23:0] ch_quotient;
    logic [13:0] ch_rem_bus;

    int n_vec;
    int n_miss;

    smalldiv_digit_lut #(
        .DIVIDER_VALUE(5), .DIVIDER_WIDTH(3), .DIGIT_WIDTH(3), .REGISTER_OUT(1'b1)
    ) u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend_digit(dividend_digit), .last_remainder(last_remainder),
        .quotient(quotient), .remainder(remainder)
    );

    smalldiv_digit_lut #(
        .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .DIGIT_WIDTH(4), .REGISTER_OUT(1'b0)
    ) u_comb (
        .clock(clock), .reset(reset), .enable(enable),
        .dividend_digit(c1_digit), .last_remainder(c1_last),
        .quotient(c1_quot), .remainder(c1_rem)
    );

    assign ch_rem_bus[13:12] = 2'd0;

    for (genvar k = 0; k < 6; k++) begin : g_chain
        smalldiv_digit_lut #(
            .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .DIGIT_WIDTH(4), .REGISTER_OUT(1'b0)
        ) u_stage (
            .clock(clock), .reset(reset), .enable(enable),
            .dividend_digit(ch_dividend[4*k +: 4]),
            .last_remainder(ch_rem_bus[2*k+2 +: 2]),
            .quotient(ch_quotient[4*k +: 4]),
            .remainder(ch_rem_bus[2*k +: 2])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary arithmetic on V = r*2^digit_bits + d.
    function automatic int ref_q(input int r, input int d, input int dv, input int dbits);
        return ((r * (1 << dbits) + d) / dv) % (1 << dbits);
    endfunction

    function automatic int ref_r(input int r, input int d, input int dv, input int dbits);
        return (r * (1 << dbits) + d) % dv;
    endfunction

    // Advance one clock and land #1 after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_and_check(input string tag, input int r, input int d);
        last_remainder = 3'(r);
        dividend_digit = 3'(d);
        enable         = 1'b1;
        tick();
        check_eq({tag, "_q"}, 32'(quotient),  32'(ref_q(r, d, 5, 3)));
        check_eq({tag, "_r"}, 32'(remainder), 32'(ref_r(r, d, 5, 3)));
    endtask

    initial begin
        int exp_q;
        int exp_r;
        int rr;
        int dd;
        logic [23:0] dvd;

        n_vec  = 0;
        n_miss = 0;
        reset          = 1'b0;
        enable         = 1'b0;
        dividend_digit = 3'd0;
        last_remainder = 3'd0;
        c1_digit       = 4'd0;
        c1_last        = 2'd0;
        ch_dividend    = 24'd0;

        // Power-on reset.
        #2 reset = 1'b1;
        #1;
        check_eq("por_q", 32'(quotient), 32'd0);
        check_eq("por_r", 32'(remainder), 32'd0);
        tick();
        #2 reset = 1'b0;

        // Directed values.
        apply_and_check("v21", 2, 5);
        check_eq("v21_q_lit", 32'(quotient), 32'd4);
        check_eq("v21_r_lit", 32'(remainder), 32'd1);

        // Async reset between edges clears at once.
        #2 reset = 1'b1;
        #1;
        check_eq("arst_q", 32'(quotient), 32'd0);
        check_eq("arst_r", 32'(remainder), 32'd0);
        last_remainder = 3'd3;
        dividend_digit = 3'd4;
        enable         = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        check_eq("post_rst_hold_q", 32'(quotient), 32'd0);
        check_eq("post_rst_hold_r", 32'(remainder), 32'd0);
        apply_and_check("first_en", 3, 4);

        apply_and_check("v39", 4, 7);
        check_eq("v39_q_lit", 32'(quotient), 32'd7);
        check_eq("v39_r_lit", 32'(remainder), 32'd4);

        // Exhaustive legal sweep, enable every cycle.
        for (int r = 0; r < 5; r++) begin
            for (int d = 0; d < 8; d++) begin
                apply_and_check("sweep", r, d);
            end
        end

        // Load then hold with enable low.
        apply_and_check("hold_load", 0, 6);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            last_remainder = 3'(i + 1);
            dividend_digit = 3'(7 - i);
            tick();
            check_eq("hold_q", 32'(quotient), 32'd1);
            check_eq("hold_r", 32'(remainder), 32'd1);
        end
        apply_and_check("reenable", 1, 2);

        // Illegal remainder input: truncated quotient, true remainder.
        apply_and_check("illegal77", 7, 7);
        check_eq("illegal_q_lit", 32'(quotient), 32'd4);
        check_eq("illegal_r_lit", 32'(remainder), 32'd3);

        // Randomized traffic including illegal remainders and enable gaps.
        exp_q = 32'(quotient);
        exp_r = 32'(remainder);
        for (int i = 0; i < 300; i++) begin
            rr = int'($urandom_range(7, 0));
            dd = int'($urandom_range(7, 0));
            last_remainder = 3'(rr);
            dividend_digit = 3'(dd);
            enable         = ($urandom_range(3, 0) != 0);
            if (enable) begin
                exp_q = ref_q(rr, dd, 5, 3);
                exp_r = ref_r(rr, dd, 5, 3);
            end
            tick();
            check_eq("rand_q", 32'(quotient), 32'(exp_q));
            check_eq("rand_r", 32'(remainder), 32'(exp_r));
            check_eq("rand_r_bound", 32'(remainder < 3'd5), 32'd1);
        end

        // Combinational stage: same-cycle result, reset has no effect.
        c1_last  = 2'd2;
        c1_digit = 4'd15;
        reset    = 1'b1;
        #1;
        check_eq("comb47_q", 32'(c1_quot), 32'd15);
        check_eq("comb47_r", 32'(c1_rem), 32'd2);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rr = int'($urandom_range(3, 0));
            dd = int'($urandom_range(15, 0));
            c1_last  = 2'(rr);
            c1_digit = 4'(dd);
            #1;
            check_eq("comb_q", 32'(c1_quot), 32'(ref_q(rr, dd, 3, 4)));
            check_eq("comb_r", 32'(c1_rem), 32'(ref_r(rr, dd, 3, 4)));
        end

        // Six-stage chain as a full long divider.
        ch_dividend = 24'd131071;
        #1;
        check_eq("chain_q", 32'(ch_quotient), 32'd43690);
        check_eq("chain_r", 32'(ch_rem_bus[1:0]), 32'd1);
        for (int i = 0; i < 40; i++) begin
            dvd = 24'($urandom());
            ch_dividend = dvd;
            #1;
            check_eq("chain_rand_q", 32'(ch_quotient), 32'(dvd) / 32'd3);
            check_eq("chain_rand_r", 32'(ch_rem_bus[1:0]), 32'(dvd) % 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_smalldiv_digit_lut
